// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register for the 16-bit five-stage core: captures decoded control
// and operands, inserts load-use / flush / halt bubbles and drives the front-end stall.
module id_ex_pipe #(
  parameter int DW   = 16,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic            id_halt,
  input  logic            id_memtoreg,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_alusrc,
  input  logic            id_regwrite,
  input  logic            id_mem,
  input  logic            id_modify,
  input  logic            id_shift,
  input  logic [2:0]      id_aluop,
  input  logic [3:0]      id_rs,
  input  logic [3:0]      id_rt,
  input  logic [3:0]      id_rd,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic [DW-1:0]   id_rs_data,
  input  logic [DW-1:0]   id_rt_data,
  input  logic [DW-1:0]   id_imm,
  input  logic [DW-1:0]   id_pc2,
  input  logic            flush,
  input  logic            ex_hold,
  output logic            ex_valid,
  output logic            ex_halt,
  output logic            ex_memtoreg,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_alusrc,
  output logic            ex_regwrite,
  output logic            ex_mem,
  output logic            ex_modify,
  output logic            ex_shift,
  output logic [2:0]      ex_aluop,
  output logic [3:0]      ex_rs,
  output logic [3:0]      ex_rt,
  output logic [3:0]      ex_rd,
  output logic [DW-1:0]   ex_rs_data,
  output logic [DW-1:0]   ex_rt_data,
  output logic [DW-1:0]   ex_imm,
  output logic [DW-1:0]   ex_pc2,
  output logic            id_stall,
  output logic            halted,
  output logic [CNTW-1:0] bubble_cnt
);

  typedef enum logic {RUN, HALTED} state_t;
  state_t state;

  logic haz;
  logic bubble;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (&c) ? c : c + {{(CNTW-1){1'b0}}, 1'b1};
  endfunction

  // Register 0 is hardwired, so a load targeting it can never create a dependency.
  assign haz = id_valid & ex_valid & ex_memread & (ex_rd != 4'd0) &
               ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

  assign halted   = (state == HALTED);
  assign id_stall = (haz | ex_hold | halted) & ~flush;
  assign bubble   = flush | halted | haz;

  // ---- ID -> EX stage boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      bubble_cnt  <= '0;
      ex_valid    <= 1'b0;
      ex_halt     <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_mem      <= 1'b0;
      ex_modify   <= 1'b0;
      ex_shift    <= 1'b0;
      ex_aluop    <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_pc2      <= '0;
    end else if (!ex_hold) begin
      if (bubble) begin
        // Only true load-use bubbles are counted, not flush or halt slots.
        if (!flush && !halted)
          bubble_cnt <= sat_inc(bubble_cnt);
        ex_valid    <= 1'b0;
        ex_halt     <= 1'b0;
        ex_memtoreg <= 1'b0;
        ex_memread  <= 1'b0;
        ex_memwrite <= 1'b0;
        ex_alusrc   <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_mem      <= 1'b0;
        ex_modify   <= 1'b0;
        ex_shift    <= 1'b0;
        ex_aluop    <= '0;
        ex_rs       <= '0;
        ex_rt       <= '0;
        ex_rd       <= '0;
        ex_rs_data  <= '0;
        ex_rt_data  <= '0;
        ex_imm      <= '0;
        ex_pc2      <= '0;
      end else begin
        if (id_valid && id_halt)
          state <= HALTED;
        ex_valid    <= id_valid;
        ex_halt     <= id_valid & id_halt;
        ex_memtoreg <= id_valid & id_memtoreg;
        ex_memread  <= id_valid & id_memread;
        ex_memwrite <= id_valid & id_memwrite;
        ex_alusrc   <= id_valid & id_alusrc;
        ex_regwrite <= id_valid & id_regwrite;
        ex_mem      <= id_valid & id_mem;
        ex_modify   <= id_valid & id_modify;
        ex_shift    <= id_valid & id_shift;
        ex_aluop    <= id_aluop;
        ex_rs       <= id_rs;
        ex_rt       <= id_rt;
        ex_rd       <= id_rd;
        ex_rs_data  <= id_rs_data;
        ex_rt_data  <= id_rt_data;
        ex_imm      <= id_imm;
        ex_pc2      <= id_pc2;
      end
    end
  end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

ID/EX pipeline register for the 16-bit five-stage pipelined core. It sits directly downstream of the instruction decoder and captures the decoder's control bits and the decode-stage operands for the execute stage. It also detects load-use hazards, inserts bubbles, and handles flush, downstream hold and HLT. It drives the stall request back to the PC and IF/ID registers.

## Interface
Parameters:
- DW, 16, datapath width
- CNTW, 16, width of the bubble counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_halt  in  1  ID instruction is HLT (opcode 4'b1111)
- id_memtoreg, id_memread, id_memwrite, id_alusrc, id_regwrite, id_mem, id_modify, id_shift  in  1 each  decoder control bits
- id_aluop  in  3  decoder ALU op
- id_rs, id_rt, id_rd  in  4 each  register specifiers after decoder source muxing
- id_uses_rs, id_uses_rt  in  1 each  ID actually reads rs / rt
- id_rs_data, id_rt_data, id_imm, id_pc2  in  DW each  operands, sign-extended immediate, PC+2
- flush  in  1  squash the ID instruction (taken branch resolved downstream)
- ex_hold  in  1  EX/MEM cannot accept; freeze this register
- ex_* outputs  out  same widths as the id_* inputs above, except id_uses_*  registered copies
- ex_valid  out  1  EX holds a real instruction
- id_stall  out  1  combinational: freeze PC and IF/ID this cycle
- halted  out  1  HLT has entered EX; pipeline front end stopped
- bubble_cnt  out  CNTW  load-use bubbles inserted since reset, saturating

## Operation
- Hazard: haz = id_valid & ex_valid & ex_memread & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)). Register 0 never causes a hazard.
- id_stall = (haz | ex_hold | halted) & ~flush.
- Per-edge priority, highest first:
  1. **rst**: async clear.
  2. **ex_hold**: all ex_* are held, including ex_valid.
  3. **flush**: load a bubble.
  4. **halted**: load a bubble.
  5. **haz**: load a bubble and increment bubble_cnt.
  6. **Otherwise**: capture all id_* fields, with ex_valid = id_valid.
- A bubble is ex_valid=0, every control bit 0, ex_aluop=0, and all data and specifier fields 0.
- Invalid capture: when id_valid=0, control bits are forced to 0, so a non-valid slot never writes registers or memory.
- State machine has two states:
  - **RUN**: on a normal capture with id_valid & id_halt, load HLT into EX (ex_halt=1, ex_valid=1) and go to HALTED.
  - **HALTED**: only rst leaves this state.
- halted = (state == HALTED).
- flush and halt in the same cycle: flush wins. HLT is dropped and the state stays RUN.
- bubble_cnt increments by 1 per inserted load-use bubble only; flush and halt bubbles are not counted. It saturates at all-ones, with no wrap.

## Timing
- Reset values: every ex_* = 0, ex_valid=0, halted=0, bubble_cnt=0, state RUN.
- Latency: one cycle from ID inputs to ex_* outputs.
- Load-use costs exactly one bubble. The cycle after the bubble, ex_memread=0, so haz drops and the stalled ID instruction is captured.
- id_stall is combinational and is valid in the same cycle as its inputs. Upstream must sample it before the clock edge.
- ex_hold and haz together: hold wins. No bubble is inserted and the counter is not incremented. Hazard detection uses the held EX contents, so the bubble is inserted once hold releases.
- rst mid-operation clears the register and state immediately, without waiting for a clock edge. The first capture occurs on the first edge after rst deasserts.

## Test plan
- **Reset:** Assert rst mid-stream with ex_valid=1 and bubble_cnt=5. Required: all outputs 0 asynchronously, before the next edge.
- **Load-use:** EX holds a LW with ex_rd=3; ID holds ADD with rs=3 and uses_rs=1. Required: id_stall=1; the next edge gives ex_valid=0 and bubble_cnt=1; the following edge captures the ADD.
- **No false hazard:** Run the same setup with ex_rd=0, or with uses_rs=0 and rs=3. Required: id_stall=0, no bubble, and the ADD is captured directly.
- **Flush vs halt:** Present HLT with flush=1. Required: bubble loaded, halted=0. Present HLT without flush. Required: ex_halt=1, halted=1, id_stall=1, and all later edges load bubbles.
- **Hold:** Assert ex_hold for 3 cycles during a hazard. Required: ex_* frozen, bubble_cnt unchanged; after release, one bubble and bubble_cnt +1.
- **Saturation:** Preload bubble_cnt to 16'hFFFF via 65535 hazards, then trigger one more. Required: bubble_cnt stays 16'hFFFF.
